// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared encodings for multicycle_alu: FunSel op codes, FSM
//             states, flag bit positions and flag-update helper functions.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Low four FunSel bits of a single-cycle operation
  typedef enum logic [3:0] {
    OP_PASS_A = 4'd0,
    OP_PASS_B = 4'd1,
    OP_NOT_A  = 4'd2,
    OP_NOT_B  = 4'd3,
    OP_ADD    = 4'd4,
    OP_ADC    = 4'd5,
    OP_SUB    = 4'd6,
    OP_AND    = 4'd7,
    OP_OR     = 4'd8,
    OP_XOR    = 4'd9,
    OP_NAND   = 4'd10,
    OP_LSL    = 4'd11,
    OP_LSR    = 4'd12,
    OP_ASR    = 4'd13,
    OP_ROL    = 4'd14,
    OP_ROR    = 4'd15
  } alu_op_e;

  // Full six-bit codes of the iterative operations
  typedef enum logic [5:0] {
    FS_MULU = 6'b100000,
    FS_DIVU = 6'b100001,
    FS_REMU = 6'b100010
  } muldiv_fs_e;

  // FunSel bit positions
  localparam int c_fs_muldiv_bit = 5;
  localparam int c_fs_full_bit   = 4;

  // FlagsOut bit positions: {Z,C,N,O}
  localparam int c_flag_z = 3;
  localparam int c_flag_c = 2;
  localparam int c_flag_n = 1;
  localparam int c_flag_o = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_ITER = 2'd1,
    DIV_ITER = 2'd2
  } alu_state_e;

  // Operations that produce a meaningful carry/borrow/shifted-out bit
  function automatic logic op_sets_c(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) ||
           (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // Operations that produce a two's-complement overflow indication
  function automatic logic op_sets_o(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
//  Module   : alu_muldiv_iter
//  Brief    : Iterative unsigned engine, one bit per clock. Shift-add
//             multiply or restoring divide over WIDTH iterations. The
//             hi/lo registers are shared: product high/low for multiply,
//             partial remainder/quotient for divide. o_hi/o_lo present the
//             result of the current iteration, so on o_last they carry the
//             final answer for the parent to register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] c_last_cnt = CW'(WIDTH - 1);

  logic             run_q,  run_d;
  logic             div_q,  div_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic [WIDTH-1:0] hi_q,   hi_d;
  logic [WIDTH-1:0] lo_q,   lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_diff;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;

  // One iteration of multiply or divide computed from the current registers
  always_comb begin
    w_step_hi  = '0;
    w_step_lo  = '0;
    w_mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    w_div_sh   = {hi_q, lo_q[WIDTH-1]};
    w_div_diff = w_div_sh - {1'b0, opnd_q};
    if (div_q) begin
      // Restoring step: keep the subtraction only if it did not go negative
      if (!w_div_diff[WIDTH]) begin
        w_step_hi = w_div_diff[WIDTH-1:0];
        w_step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        w_step_hi = w_div_sh[WIDTH-1:0];
        w_step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add step: conditionally add multiplicand, shift right by one
      w_step_hi = w_mul_sum[WIDTH:1];
      w_step_lo = {w_mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign o_hi   = w_step_hi;
  assign o_lo   = w_step_lo;
  assign o_last = run_q && (cnt_q == c_last_cnt);

  // Next-state: load operands on start, otherwise advance one iteration
  always_comb begin
    run_d  = run_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (i_start) begin
      run_d  = 1'b1;
      div_d  = i_div;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = i_div ? i_a : i_b;
      opnd_d = i_div ? i_b : i_a;
    end else if (run_q) begin
      hi_d  = w_step_hi;
      lo_d  = w_step_lo;
      cnt_d = cnt_q + 1'b1;
      if (o_last) begin
        run_d = 1'b0;
      end
    end
  end

  // Engine registers
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      run_q  <= run_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_alu.sv
// ============================================================================
//  Module   : multicycle_alu
//  Brief    : WIDTH-generic ALU with Start/Busy/Done handshake, registered
//             result and flags {Z,C,N,O}. Single-cycle logic/arith/shift ops
//             on full or half width; optional iterative MULU/DIVU/REMU.
//  Config   : define MULDIV_EN to build the iterative multiply/divide path;
//             without it every FunSel[5]=1 code completes as illegal.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [5:0]       FunSel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WF,
  output logic             Busy,
  output logic             Done,
  output logic             IllegalOp,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut
);

  import alu_pkg::*;

  localparam int HALF = WIDTH / 2;

  alu_state_e       state_q,   state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [3:0]       flags_q,   flags_d;
  logic             done_q,    done_d;
  logic             illegal_q, illegal_d;

  // Single-cycle results: index 0 = half width, index 1 = full width
  logic [1:0][WIDTH-1:0] sc_res;
  logic [1:0]            sc_c;
  logic [1:0]            sc_v;

  logic             w_full;
  alu_op_e          w_op;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_neg;

  // Same operation table evaluated on both operand widths
  for (genvar gi = 0; gi < 2; gi++) begin : g_sc
    localparam int N = (gi == 1) ? WIDTH : HALF;

    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_r;
    logic [N:0]   w_s;
    logic         w_c;
    logic         w_v;

    // Result, carry-type bit and overflow for one width
    always_comb begin
      w_a = A[N-1:0];
      w_b = B[N-1:0];
      w_r = '0;
      w_s = '0;
      w_c = 1'b0;
      w_v = 1'b0;
      case (alu_op_e'(FunSel[3:0]))
        OP_PASS_A: w_r = w_a;
        OP_PASS_B: w_r = w_b;
        OP_NOT_A:  w_r = ~w_a;
        OP_NOT_B:  w_r = ~w_b;
        OP_ADD: begin
          w_s = {1'b0, w_a} + {1'b0, w_b};
          w_r = w_s[N-1:0];
          w_c = w_s[N];
          w_v = (w_a[N-1] == w_b[N-1]) && (w_r[N-1] != w_a[N-1]);
        end
        OP_ADC: begin
          w_s = {1'b0, w_a} + {1'b0, w_b} + (N+1)'(flags_q[c_flag_c]);
          w_r = w_s[N-1:0];
          w_c = w_s[N];
          w_v = (w_a[N-1] == w_b[N-1]) && (w_r[N-1] != w_a[N-1]);
        end
        OP_SUB: begin
          // Bit N of the extended difference is set exactly when B > A
          w_s = {1'b0, w_a} - {1'b0, w_b};
          w_r = w_s[N-1:0];
          w_c = w_s[N];
          w_v = (w_a[N-1] != w_b[N-1]) && (w_r[N-1] != w_a[N-1]);
        end
        OP_AND:  w_r = w_a & w_b;
        OP_OR:   w_r = w_a | w_b;
        OP_XOR:  w_r = w_a ^ w_b;
        OP_NAND: w_r = ~(w_a & w_b);
        OP_LSL: begin
          w_r = {w_a[N-2:0], 1'b0};
          w_c = w_a[N-1];
        end
        OP_LSR: begin
          w_r = {1'b0, w_a[N-1:1]};
          w_c = w_a[0];
        end
        OP_ASR: begin
          w_r = {w_a[N-1], w_a[N-1:1]};
          w_c = w_a[0];
        end
        OP_ROL: begin
          w_r = {w_a[N-2:0], w_a[N-1]};
          w_c = w_a[N-1];
        end
        OP_ROR: begin
          w_r = {w_a[0], w_a[N-1:1]};
          w_c = w_a[0];
        end
        default: w_r = '0;
      endcase
    end

    assign sc_res[gi] = WIDTH'(w_r);
    assign sc_c[gi]   = w_c;
    assign sc_v[gi]   = w_v;
  end

  assign w_full   = FunSel[c_fs_full_bit];
  assign w_op     = alu_op_e'(FunSel[3:0]);
  assign w_sc_res = sc_res[w_full];
  assign w_sc_neg = w_full ? w_sc_res[WIDTH-1] : w_sc_res[HALF-1];

`ifdef MULDIV_EN
  logic             wf_q,  wf_d;
  logic             rem_q, rem_d;
  logic             eng_start;
  logic             eng_div;
  logic             eng_last;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] w_dz_res;
  logic [WIDTH-1:0] w_mc_res;

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (Clock),
    .rst     (Reset),
    .i_start (eng_start),
    .i_div   (eng_div),
    .i_a     (A),
    .i_b     (B),
    .o_last  (eng_last),
    .o_lo    (eng_lo),
    .o_hi    (eng_hi)
  );

  assign Busy = (state_q != IDLE);
`else
  assign Busy = 1'b0;
`endif

  // Accept Start in IDLE, run single-cycle ops, launch or finish iterations
  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef MULDIV_EN
    wf_d      = wf_q;
    rem_d     = rem_q;
    eng_start = 1'b0;
    eng_div   = 1'b0;
    w_dz_res  = (FunSel == FS_DIVU) ? '1 : A;
    w_mc_res  = '0;
`endif
    if (state_q == IDLE) begin
      if (Start) begin
        if (!FunSel[c_fs_muldiv_bit]) begin
          alu_out_d = w_sc_res;
          done_d    = 1'b1;
          if (WF) begin
            flags_d[c_flag_z] = (w_sc_res == '0);
            flags_d[c_flag_n] = w_sc_neg;
            if (op_sets_c(w_op)) flags_d[c_flag_c] = sc_c[w_full];
            if (op_sets_o(w_op)) flags_d[c_flag_o] = sc_v[w_full];
          end
        end
`ifdef MULDIV_EN
        else if (FunSel == FS_MULU) begin
          state_d   = MUL_ITER;
          eng_start = 1'b1;
          wf_d      = WF;
        end else if ((FunSel == FS_DIVU) || (FunSel == FS_REMU)) begin
          if (B == '0) begin
            // Divide by zero short-circuits with a fixed result
            alu_out_d = w_dz_res;
            done_d    = 1'b1;
            if (WF) begin
              flags_d[c_flag_z] = (w_dz_res == '0);
              flags_d[c_flag_n] = w_dz_res[WIDTH-1];
              flags_d[c_flag_c] = 1'b0;
              flags_d[c_flag_o] = 1'b1;
            end
          end else begin
            state_d   = DIV_ITER;
            eng_start = 1'b1;
            eng_div   = 1'b1;
            wf_d      = WF;
            rem_d     = (FunSel == FS_REMU);
          end
        end
`endif
        else begin
          alu_out_d = '0;
          done_d    = 1'b1;
          illegal_d = 1'b1;
        end
      end
    end
`ifdef MULDIV_EN
    else if (eng_last) begin
      w_mc_res  = ((state_q == DIV_ITER) && rem_q) ? eng_hi : eng_lo;
      state_d   = IDLE;
      alu_out_d = w_mc_res;
      done_d    = 1'b1;
      if (wf_q) begin
        flags_d[c_flag_z] = (w_mc_res == '0);
        flags_d[c_flag_n] = w_mc_res[WIDTH-1];
        flags_d[c_flag_c] = (state_q == MUL_ITER) && (eng_hi != '0);
        flags_d[c_flag_o] = (state_q == MUL_ITER) && (eng_hi != '0);
      end
    end
`endif
  end

`ifdef MULDIV_EN
  // Operation attributes held for the duration of an iterative op
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wf_q  <= 1'b0;
      rem_q <= 1'b0;
    end else begin
      wf_q  <= wf_d;
      rem_q <= rem_d;
    end
  end
`endif

  // Architectural state: FSM, result, flags and completion pulses
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      alu_out_q <= '0;
      flags_q   <= 4'b0000;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign Done      = done_q;
  assign IllegalOp = illegal_q;
  assign ALUOut    = alu_out_q;
  assign FlagsOut  = flags_q;

endmodule

`default_nettype wire
